// File: rtl/serial_regbank.sv
// Serial-bus register bank with strobe/ack handshake, read-only status bits and self-clearing pulse bits.
// Latency 1: ack/data_rd/adr_err/wr_stb follow each strobe by one cycle. Fully pipelined, no backpressure.
// REGBANK_WRCNT_EN adds a 16-bit saturating write counter at address NREG.
module serial_regbank #(
    parameter int NREG      = 11,
    parameter int ADRSIZE   = 7,
    parameter int REGSIZE   = 32,
    parameter int PULSE_LEN = 1,
    parameter logic [NREG*REGSIZE-1:0] INIT_VEC   = '0,
    parameter logic [NREG*REGSIZE-1:0] RO_MASK    = '0,
    parameter logic [NREG*REGSIZE-1:0] PULSE_MASK = '0
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      strobe,
    input  logic [ADRSIZE:0]          adr_in,
    input  logic [REGSIZE-1:0]        data_wr,
    output logic [REGSIZE-1:0]        data_rd,
    output logic                      ack,
    output logic                      adr_err,
    input  logic [NREG*REGSIZE-1:0]   hw_rd,
    output logic [NREG*REGSIZE-1:0]   regs,
    output logic [NREG-1:0]           wr_stb
);
    localparam int CW = $clog2(PULSE_LEN + 1);
    localparam logic [CW-1:0]      PLOAD  = CW'(PULSE_LEN);
    localparam logic [ADRSIZE-1:0] NREG_A = ADRSIZE'(NREG);

    logic               wr;
    logic [ADRSIZE-1:0] adr;
    logic               adr_bad;
    logic [NREG-1:0]    wr_hit;
    logic [REGSIZE-1:0] reg_q   [NREG];
    logic [REGSIZE-1:0] rd_word [NREG];
    logic [REGSIZE-1:0] rd_val;

    assign wr  = adr_in[ADRSIZE];
    assign adr = adr_in[ADRSIZE-1:0];

`ifdef REGBANK_WRCNT_EN
    logic [15:0] wrcnt_q;
    assign adr_bad = adr > NREG_A;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrcnt_q <= '0;
        end else if (strobe && wr) begin
            if (adr < NREG_A) begin
                if (wrcnt_q != 16'hFFFF) wrcnt_q <= wrcnt_q + 16'd1;
            end else if (adr == NREG_A) begin
                wrcnt_q <= '0;
            end
        end
    end
`else
    assign adr_bad = adr >= NREG_A;
`endif

    for (genvar r = 0; r < NREG; r++) begin : g_reg
        localparam logic [REGSIZE-1:0] RO = RO_MASK[r*REGSIZE +: REGSIZE];
        localparam logic [REGSIZE-1:0] PM = PULSE_MASK[r*REGSIZE +: REGSIZE] & ~RO;
        localparam logic [REGSIZE-1:0] RV = INIT_VEC[r*REGSIZE +: REGSIZE] & ~RO & ~PM;

        logic [CW-1:0] cnt_q;

        assign wr_hit[r] = strobe && wr && (adr == ADRSIZE'(r));
        assign regs[r*REGSIZE +: REGSIZE] = reg_q[r];
        assign rd_word[r] = (reg_q[r] & ~RO) | (hw_rd[r*REGSIZE +: REGSIZE] & RO);

        // A write always reloads or kills the pulse timer, so it wins over a same-edge expiry.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                reg_q[r] <= RV;
                cnt_q    <= '0;
            end else if (wr_hit[r]) begin
                reg_q[r] <= data_wr & ~RO;
                cnt_q    <= (|(data_wr & PM)) ? PLOAD : '0;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) reg_q[r] <= reg_q[r] & ~PM;
            end
        end
    end

    always_comb begin
        rd_val = '0;
        for (int r = 0; r < NREG; r++) begin
            if (adr == ADRSIZE'(r)) rd_val = rd_word[r];
        end
`ifdef REGBANK_WRCNT_EN
        if (adr == NREG_A) rd_val = REGSIZE'(wrcnt_q);
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_rd <= '0;
            ack     <= 1'b0;
            adr_err <= 1'b0;
            wr_stb  <= '0;
        end else begin
            ack     <= strobe;
            adr_err <= strobe && adr_bad;
            wr_stb  <= wr_hit;
            if (strobe) data_rd <= rd_val;
        end
    end
endmodule

// File: tb/tb_serial_regbank.sv
// Bench for serial_regbank: directed vector table, hand-written pulse/reset/counter sequences,
// and randomized transactions checked against a cycle-count based reference model.
module tb_serial_regbank;
    localparam int NREG = 11;
    localparam int PL   = 4;
    localparam logic [NREG*32-1:0] INIT_V  = 352'h20 << 32;
    localparam logic [NREG*32-1:0] RO_V    = 352'h0060_0000 << (4*32);
    localparam logic [NREG*32-1:0] PULSE_V = 352'hF << (2*32);

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              strobe = 1'b0;
    logic [7:0]        adr_in = '0;
    logic [31:0]       data_wr = '0;
    logic [31:0]       data_rd;
    logic              ack, adr_err;
    logic [NREG*32-1:0] hw_rd = '0;
    logic [NREG*32-1:0] regs;
    logic [NREG-1:0]   wr_stb;

    serial_regbank #(
        .NREG(NREG), .ADRSIZE(7), .REGSIZE(32), .PULSE_LEN(PL),
        .INIT_VEC(INIT_V), .RO_MASK(RO_V), .PULSE_MASK(PULSE_V)
    ) dut (
        .clock(clock), .reset_n(reset_n), .strobe(strobe), .adr_in(adr_in),
        .data_wr(data_wr), .data_rd(data_rd), .ack(ack), .adr_err(adr_err),
        .hw_rd(hw_rd), .regs(regs), .wr_stb(wr_stb)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: stored value per register, cycle at which its pulse bits vanish.
    logic [31:0] mreg [NREG];
    int          pend [NREG];
    int          cyc = 0;
    int          wrcnt = 0;
    logic [31:0] exp_rd = '0;

    function automatic logic [31:0] ro_of(input int r);
        logic [NREG*32-1:0] v;
        v = RO_V;
        return v[r*32 +: 32];
    endfunction

    function automatic logic [31:0] pm_of(input int r);
        logic [NREG*32-1:0] v;
        v = PULSE_V;
        return v[r*32 +: 32] & ~ro_of(r);
    endfunction

    function automatic logic [31:0] vis(input int r);
        return (cyc >= pend[r]) ? (mreg[r] & ~pm_of(r)) : mreg[r];
    endfunction

    function automatic logic [NREG*32-1:0] exp_regs();
        logic [NREG*32-1:0] v;
        for (int r = 0; r < NREG; r++) v[r*32 +: 32] = vis(r);
        return v;
    endfunction

    function automatic logic [31:0] model_read(input int a);
        if (a < NREG) return (vis(a) & ~ro_of(a)) | (hw_rd[a*32 +: 32] & ro_of(a));
`ifdef REGBANK_WRCNT_EN
        if (a == NREG) return 32'(wrcnt);
`endif
        return 32'h0;
    endfunction

    function automatic logic model_bad(input int a);
`ifdef REGBANK_WRCNT_EN
        return a > NREG;
`else
        return a >= NREG;
`endif
    endfunction

    task automatic model_reset();
        logic [NREG*32-1:0] v;
        v = INIT_V & ~RO_V & ~PULSE_V;
        for (int r = 0; r < NREG; r++) begin
            mreg[r] = v[r*32 +: 32];
            pend[r] = 0;
        end
        wrcnt = 0;
        exp_rd = '0;
    endtask

    task automatic chk(input string nm, input logic [NREG*32-1:0] act, input logic [NREG*32-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock cycle; called at posedge+1, returns at the following posedge+1.
    task automatic step(input logic s, input logic w, input int a, input logic [31:0] d);
        logic [NREG-1:0] e_stb;
        logic            e_err;
        e_stb = '0;
        e_err = 1'b0;
        strobe  = s;
        adr_in  = {w, 7'(a)};
        data_wr = d;
        if (s) begin
            exp_rd = model_read(a);
            e_err  = model_bad(a);
            if (w && a < NREG) e_stb[a] = 1'b1;
        end
        @(posedge clock);
        cyc++;
        if (s && w) begin
            if (a < NREG) begin
                mreg[a] = d & ~ro_of(a);
                pend[a] = ((d & pm_of(a)) != 0) ? cyc + PL : 0;
                if (wrcnt < 65535) wrcnt++;
            end else if (a == NREG) begin
`ifdef REGBANK_WRCNT_EN
                wrcnt = 0;
`endif
            end
        end
        #1;
        strobe = 1'b0;
        chk("ack", ack, s);
        chk("adr_err", adr_err, e_err);
        chk("data_rd", data_rd, exp_rd);
        chk("wr_stb", wr_stb, e_stb);
        chk("regs", regs, exp_regs());
    endtask

    task automatic async_reset();
        reset_n = 1'b0;
        #2;
        model_reset();
        chk("rst_regs", regs, exp_regs());
        chk("rst_ack", ack, 1'b0);
        chk("rst_data_rd", data_rd, 32'h0);
        chk("rst_wr_stb", wr_stb, '0);
        chk("rst_adr_err", adr_err, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        cyc++;
        #1;
        chk("post_rst_regs", regs, exp_regs());
    endtask

    typedef struct {
        logic        wr;
        int          adr;
        logic [31:0] dat;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [9];
    int   hi_cnt;

    initial begin
        tbl[0] = '{1'b0, 1,  32'h0,         32'h0000_0020, 1'b0};
        tbl[1] = '{1'b1, 0,  32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        tbl[2] = '{1'b0, 0,  32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[3] = '{1'b1, 4,  32'hFFFF_FFFF, 32'h0060_0000, 1'b0};
        tbl[4] = '{1'b0, 4,  32'h0,         32'hFFFF_FFFF, 1'b0};
        tbl[5] = '{1'b1, 12, 32'h1234_5678, 32'h0000_0000, 1'b1};
        tbl[6] = '{1'b0, 3,  32'h0,         32'h0000_0000, 1'b0};
        tbl[7] = '{1'b0, 10, 32'h0,         32'h0000_0000, 1'b0};
`ifdef REGBANK_WRCNT_EN
        tbl[8] = '{1'b0, 11, 32'h0,         32'h0000_0002, 1'b0};
`else
        tbl[8] = '{1'b0, 11, 32'h0,         32'h0000_0000, 1'b1};
`endif

        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("init_regs", regs, exp_regs());
        chk("init_ack", ack, 1'b0);
        chk("init_data_rd", data_rd, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        cyc++;
        #1;

        hw_rd[4*32 +: 32] = 32'h0060_0000;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, tbl[i].wr, tbl[i].adr, tbl[i].dat);
            chk($sformatf("tbl%0d_rd", i), data_rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_err", i), adr_err, tbl[i].exp_err);
        end
        step(1'b0, 1'b0, 0, 32'h0);
        chk("wr_stb_clear", wr_stb, '0);

        hw_rd[4*32 +: 32] = 32'h0;
        step(1'b1, 1'b0, 4, 32'h0);
        chk("ro_hw0", data_rd, 32'hFF9F_FFFF);

        // Single pulse: exactly PL cycles visible.
        hi_cnt = 0;
        step(1'b1, 1'b1, 2, 32'hABCD_0005);
        for (int i = 0; i < 8; i++) begin
            if (regs[2*32 +: 4] == 4'h5) hi_cnt++;
            step(1'b0, 1'b0, 0, 32'h0);
        end
        chk("pulse_len", 32'(hi_cnt), 32'd4);
        chk("pulse_keep_hi", regs[2*32 +: 32], 32'hABCD_0000);

        // Rewrite two cycles in extends to six.
        hi_cnt = 0;
        step(1'b1, 1'b1, 2, 32'h5);
        if (regs[2*32 +: 4] == 4'h5) hi_cnt++;
        step(1'b0, 1'b0, 0, 32'h0);
        if (regs[2*32 +: 4] == 4'h5) hi_cnt++;
        step(1'b1, 1'b1, 2, 32'h5);
        for (int i = 0; i < 8; i++) begin
            if (regs[2*32 +: 4] == 4'h5) hi_cnt++;
            step(1'b0, 1'b0, 0, 32'h0);
        end
        chk("pulse_extend", 32'(hi_cnt), 32'd6);

        // Zero write kills an active pulse immediately.
        step(1'b1, 1'b1, 2, 32'h3);
        step(1'b1, 1'b1, 2, 32'h0);
        chk("pulse_kill", regs[2*32 +: 32], 32'h0);

        step(1'b1, 1'b1, 12, 32'hFFFF_FFFF);
        chk("oor_err", adr_err, 1'b1);
        step(1'b1, 1'b1, 127, 32'hFFFF_FFFF);
        chk("oor_max_rd", data_rd, 32'h0);

        step(1'b1, 1'b1, 2, 32'hF);
        step(1'b0, 1'b0, 0, 32'h0);
        async_reset();
        chk("rst_pulse", regs[2*32 +: 32], 32'h0);

`ifdef REGBANK_WRCNT_EN
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 0, 32'(i));
        step(1'b1, 1'b0, 11, 32'h0);
        chk("wrcnt3", data_rd, 32'd3);
        step(1'b1, 1'b1, 11, 32'h0);
        chk("wrcnt_clr_err", adr_err, 1'b0);
        step(1'b1, 1'b0, 11, 32'h0);
        chk("wrcnt0", data_rd, 32'd0);
`else
        step(1'b1, 1'b1, 11, 32'h0);
        chk("adr11_err", adr_err, 1'b1);
`endif

        for (int i = 0; i < 400; i++) begin
            if ((i % 8) == 0)
                for (int r = 0; r < NREG; r++) hw_rd[r*32 +: 32] = $urandom();
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 15) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 13),
                 ($urandom_range(0, 3) == 0) ? 32'(0) : $urandom());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, limit 500000 time units");
        $fatal(1);
    end
endmodule
